// File: rtl/game_pkg.sv
// Shared game-level types and screen constants, used by the menu controller and the colour mapper.
// The clip helpers turn a centre/half-extent pair into a bounded edge coordinate.
package game_pkg;

  typedef enum logic [1:0] {
    TITLE     = 2'd0,
    COUNTDOWN = 2'd1,
    PLAY      = 2'd2,
    GAMEOVER  = 2'd3
  } game_state_t;

  localparam logic [7:0] KEY_START       = 8'h28;
  localparam logic [9:0] H_MAX           = 10'd639;
  localparam logic [9:0] V_MAX           = 10'd479;
  localparam int         BLINK_FRAMES    = 30;
  localparam int         SECOND_FRAMES   = 60;
  localparam int         GAMEOVER_FRAMES = 180;

  // Lower edge: a negative difference means the banner hangs off the screen, so pin it to 0.
  function automatic logic [9:0] clip_lo(input logic [9:0] c, input logic [9:0] h);
    logic signed [10:0] d;
    d = $signed({1'b0, c}) - $signed({1'b0, h});
    return d[10] ? 10'd0 : d[9:0];
  endfunction

  // The sum cannot exceed 2046, so an 11-bit unsigned sum never wraps before the clamp.
  function automatic logic [9:0] clip_hi(input logic [9:0] c, input logic [9:0] h,
                                         input logic [9:0] lim);
    logic [10:0] s;
    s = {1'b0, c} + {1'b0, h};
    return (s > {1'b0, lim}) ? lim : s[9:0];
  endfunction

endpackage

// File: rtl/box_clip.sv
// Combinational banner bounding box: centre and half-extents in, screen-clamped edges out.
module box_clip
  import game_pkg::*;
(
  input  logic [9:0] i_x,
  input  logic [9:0] i_y,
  input  logic [9:0] i_half_w,
  input  logic [9:0] i_half_h,
  output logic [9:0] o_x0,
  output logic [9:0] o_x1,
  output logic [9:0] o_y0,
  output logic [9:0] o_y1
);

  assign o_x0 = clip_lo(i_x, i_half_w);
  assign o_x1 = clip_hi(i_x, i_half_w, H_MAX);
  assign o_y0 = clip_lo(i_y, i_half_h);
  assign o_y1 = clip_hi(i_y, i_half_h, V_MAX);

endmodule

// File: rtl/start_menu_ctrl.sv
// Title / countdown / play / game-over sequencer clocked once per video frame, plus the
// registered clipped bounding box of the start banner for the colour mapper.
module start_menu_ctrl
  import game_pkg::*;
(
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic       game_over,
  input  logic [9:0] StartX,
  input  logic [9:0] StartY,
  input  logic [9:0] StartWidth,
  input  logic [9:0] StartHeight,
  output logic [1:0] game_state,
  output logic       start_visible,
  output logic       game_active,
  output logic       play_start,
  output logic [1:0] countdown,
  output logic [9:0] box_x0,
  output logic [9:0] box_x1,
  output logic [9:0] box_y0,
  output logic [9:0] box_y1
);

  localparam logic [7:0] BLINK_LAST  = 8'(BLINK_FRAMES - 1);
  localparam logic [7:0] SECOND_LAST = 8'(SECOND_FRAMES - 1);
  localparam logic [7:0] GO_LAST     = 8'(GAMEOVER_FRAMES - 1);

  game_state_t r_state, w_state_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt;
  logic [7:0]  r_key_prev;
  logic        r_visible, w_visible_nxt;
  logic        r_active, w_active_nxt;
  logic        r_play_start, w_play_start_nxt;
  logic [1:0]  r_countdown, w_countdown_nxt;
  logic        w_press;
  logic [9:0]  r_box_x0, r_box_x1, r_box_y0, r_box_y1;
  logic [9:0]  w_x0, w_x1, w_y0, w_y1;

  box_clip u_box_clip (
    .i_x      (StartX),
    .i_y      (StartY),
    .i_half_w (StartWidth),
    .i_half_h (StartHeight),
    .o_x0     (w_x0),
    .o_x1     (w_x1),
    .o_y0     (w_y0),
    .o_y1     (w_y1)
  );

  // A held key produces a single press: only the frame where Enter first appears counts.
  assign w_press = (keycode == KEY_START) && (r_key_prev != KEY_START);

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_visible_nxt    = r_visible;
    w_countdown_nxt  = r_countdown;
    w_play_start_nxt = 1'b0;
    case (r_state)
      TITLE: begin
        if (w_press) begin
          w_state_nxt     = COUNTDOWN;
          w_cnt_nxt       = 8'd0;
          w_countdown_nxt = 2'd3;
          w_visible_nxt   = 1'b1;
        end else if (r_cnt == BLINK_LAST) begin
          w_cnt_nxt     = 8'd0;
          w_visible_nxt = ~r_visible;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      COUNTDOWN: begin
        if (r_cnt == SECOND_LAST) begin
          w_cnt_nxt = 8'd0;
          if (r_countdown == 2'd1) begin
            w_state_nxt      = PLAY;
            w_countdown_nxt  = 2'd0;
            w_play_start_nxt = 1'b1;
            w_visible_nxt    = 1'b0;
          end else begin
            w_countdown_nxt = r_countdown - 2'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      PLAY: begin
        w_visible_nxt = 1'b0;
        if (game_over) begin
          w_state_nxt   = GAMEOVER;
          w_cnt_nxt     = 8'd0;
          w_visible_nxt = 1'b1;
        end
      end
      GAMEOVER: begin
        w_visible_nxt = 1'b1;
        // A press landing on the timeout frame takes the same single exit.
        if (w_press || (r_cnt == GO_LAST)) begin
          w_state_nxt = TITLE;
          w_cnt_nxt   = 8'd0;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt = TITLE;
        w_cnt_nxt   = 8'd0;
      end
    endcase
    w_active_nxt = (w_state_nxt == PLAY);
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_state      <= TITLE;
      r_cnt        <= 8'd0;
      r_key_prev   <= 8'd0;
      r_visible    <= 1'b1;
      r_active     <= 1'b0;
      r_play_start <= 1'b0;
      r_countdown  <= 2'd0;
      r_box_x0     <= 10'd0;
      r_box_x1     <= 10'd0;
      r_box_y0     <= 10'd0;
      r_box_y1     <= 10'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_key_prev   <= keycode;
      r_visible    <= w_visible_nxt;
      r_active     <= w_active_nxt;
      r_play_start <= w_play_start_nxt;
      r_countdown  <= w_countdown_nxt;
      r_box_x0     <= w_x0;
      r_box_x1     <= w_x1;
      r_box_y0     <= w_y0;
      r_box_y1     <= w_y1;
    end
  end

  assign game_state    = r_state;
  assign start_visible = r_visible;
  assign game_active   = r_active;
  assign play_start    = r_play_start;
  assign countdown     = r_countdown;
  assign box_x0        = r_box_x0;
  assign box_x1        = r_box_x1;
  assign box_y0        = r_box_y0;
  assign box_y1        = r_box_y1;

endmodule

// File: tb/tb_start_menu_ctrl.sv
// Bench for start_menu_ctrl: directed sequence scenarios followed by a randomized phase,
// all checked against a frame-level behavioural model of the menu rules.
module tb_start_menu_ctrl;

  logic       frame_clk = 1'b0;
  logic       Reset;
  logic [7:0] keycode;
  logic       game_over;
  logic [9:0] StartX, StartY, StartWidth, StartHeight;
  logic [1:0] game_state;
  logic       start_visible, game_active, play_start;
  logic [1:0] countdown;
  logic [9:0] box_x0, box_x1, box_y0, box_y1;

  int n_cmp = 0;
  int n_err = 0;

  // model state: plain integers following the game rules frame by frame
  int         m_state, m_cnt, m_cd;
  bit         m_vis, m_ps;
  logic [7:0] m_kp;
  int         m_bx0, m_bx1, m_by0, m_by1;

  start_menu_ctrl dut (
    .frame_clk     (frame_clk),
    .Reset         (Reset),
    .keycode       (keycode),
    .game_over     (game_over),
    .StartX        (StartX),
    .StartY        (StartY),
    .StartWidth    (StartWidth),
    .StartHeight   (StartHeight),
    .game_state    (game_state),
    .start_visible (start_visible),
    .game_active   (game_active),
    .play_start    (play_start),
    .countdown     (countdown),
    .box_x0        (box_x0),
    .box_x1        (box_x1),
    .box_y0        (box_y0),
    .box_y1        (box_y1)
  );

  // clock
  always #5 frame_clk = ~frame_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_cd = 0; m_vis = 1'b1; m_ps = 1'b0; m_kp = 8'd0;
    m_bx0 = 0; m_bx1 = 0; m_by0 = 0; m_by1 = 0;
  endtask

  task automatic model_step();
    bit press;
    int lo;
    press = (keycode == 8'h28) && (m_kp != 8'h28);
    m_kp  = keycode;
    m_ps  = 1'b0;
    case (m_state)
      0: begin
        if (press) begin m_state = 1; m_cnt = 0; m_cd = 3; m_vis = 1'b1; end
        else if (m_cnt == 29) begin m_cnt = 0; m_vis = !m_vis; end
        else m_cnt++;
      end
      1: begin
        if (m_cnt == 59) begin
          m_cnt = 0;
          if (m_cd == 1) begin m_state = 2; m_cd = 0; m_ps = 1'b1; m_vis = 1'b0; end
          else m_cd--;
        end else m_cnt++;
      end
      2: begin
        if (game_over) begin m_state = 3; m_cnt = 0; m_vis = 1'b1; end
      end
      default: begin
        if (press || m_cnt == 179) begin m_state = 0; m_cnt = 0; m_vis = 1'b1; end
        else m_cnt++;
      end
    endcase
    lo    = int'(StartX) - int'(StartWidth);
    m_bx0 = (lo < 0) ? 0 : lo;
    m_bx1 = (int'(StartX) + int'(StartWidth) > 639) ? 639 : int'(StartX) + int'(StartWidth);
    lo    = int'(StartY) - int'(StartHeight);
    m_by0 = (lo < 0) ? 0 : lo;
    m_by1 = (int'(StartY) + int'(StartHeight) > 479) ? 479 : int'(StartY) + int'(StartHeight);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"},   32'(game_state),    32'(m_state));
    chk({tag, ".visible"}, 32'(start_visible), 32'(m_vis));
    chk({tag, ".active"},  32'(game_active),   32'(m_state == 2));
    chk({tag, ".pstart"},  32'(play_start),    32'(m_ps));
    chk({tag, ".cdown"},   32'(countdown),     32'(m_cd));
    chk({tag, ".x0"},      32'(box_x0),        32'(m_bx0));
    chk({tag, ".x1"},      32'(box_x1),        32'(m_bx1));
    chk({tag, ".y0"},      32'(box_y0),        32'(m_by0));
    chk({tag, ".y1"},      32'(box_y1),        32'(m_by1));
  endtask

  // driver: advance n frames, updating the model at each edge and checking 1 ns later
  task automatic step(input int n, input string tag);
    repeat (n) begin
      @(posedge frame_clk);
      if (Reset) model_reset(); else model_step();
      #1;
      check_all(tag);
    end
  endtask

  task automatic set_box(input int x, input int y, input int w, input int h);
    StartX = 10'(x); StartY = 10'(y); StartWidth = 10'(w); StartHeight = 10'(h);
  endtask

  initial begin
    int r;
    Reset = 1'b1; keycode = 8'd0; game_over = 1'b0;
    set_box(320, 240, 40, 10);
    #3;
    model_reset();
    check_all("reset");
    chk("reset_state", 32'(game_state), 32'd0);
    chk("reset_visible", 32'(start_visible), 32'd1);
    step(2, "reset_hold");
    Reset = 1'b0;

    // idle title blink
    for (int i = 1; i <= 65; i++) begin
      step(1, "idle");
      if (i == 30) chk("blink30", 32'(start_visible), 32'd0);
      if (i == 60) chk("blink60", 32'(start_visible), 32'd1);
    end

    // Enter held 10 frames, then the full countdown
    keycode = 8'h28;
    for (int i = 1; i <= 182; i++) begin
      step(1, "countdown");
      if (i == 10) keycode = 8'd0;
      if (i == 1)   chk("cd_enter", 32'(countdown), 32'd3);
      if (i == 61)  chk("cd_two", 32'(countdown), 32'd2);
      if (i == 121) chk("cd_one", 32'(countdown), 32'd1);
      if (i == 181) begin
        chk("play_state", 32'(game_state), 32'd2);
        chk("play_pulse", 32'(play_start), 32'd1);
        chk("play_active", 32'(game_active), 32'd1);
      end
      if (i == 182) chk("play_pulse_end", 32'(play_start), 32'd0);
    end

    // Enter in PLAY is ignored
    keycode = 8'h28;
    step(3, "play_key");
    keycode = 8'd0;
    chk("play_key_state", 32'(game_state), 32'd2);

    // game over then timeout back to TITLE
    game_over = 1'b1;
    step(1, "gameover");
    game_over = 1'b0;
    chk("go_state", 32'(game_state), 32'd3);
    step(179, "go_hold");
    chk("go_hold_state", 32'(game_state), 32'd3);
    step(1, "go_exit");
    chk("go_timeout", 32'(game_state), 32'd0);

    // game_over outside PLAY has no effect
    game_over = 1'b1;
    step(1, "title_go");
    game_over = 1'b0;
    chk("title_go_state", 32'(game_state), 32'd0);
    keycode = 8'h28;
    step(1, "press");
    keycode = 8'd0;
    step(4, "cd_run");
    game_over = 1'b1;
    step(1, "cd_go");
    game_over = 1'b0;
    chk("cd_go_state", 32'(game_state), 32'd1);

    // async reset mid-countdown, while countdown shows 2
    step(60, "cd_to_two");
    chk("cd_pre_reset", 32'(countdown), 32'd2);
    #2 Reset = 1'b1;
    #1;
    model_reset();
    chk("async_state", 32'(game_state), 32'd0);
    chk("async_cdown", 32'(countdown), 32'd0);
    chk("async_box", 32'(box_x1), 32'd0);
    check_all("async");
    step(1, "reset_mid");
    keycode = 8'h28;
    Reset = 1'b0;
    step(1, "held_at_release");
    chk("held_press", 32'(game_state), 32'd1);
    keycode = 8'd0;

    // bounding-box clamping
    set_box(20, 470, 40, 20);
    step(1, "box_a");
    chk("box_a_x0", 32'(box_x0), 32'd0);
    chk("box_a_x1", 32'(box_x1), 32'd60);
    chk("box_a_y0", 32'(box_y0), 32'd450);
    chk("box_a_y1", 32'(box_y1), 32'd479);
    set_box(320, 50, 40, 1);
    step(1, "box_b");
    chk("box_b_x0", 32'(box_x0), 32'd280);
    chk("box_b_x1", 32'(box_x1), 32'd360);
    chk("box_b_y0", 32'(box_y0), 32'd49);
    chk("box_b_y1", 32'(box_y1), 32'd51);
    set_box(1023, 1023, 1023, 1023);
    step(1, "box_max");
    chk("box_max_x1", 32'(box_x1), 32'd639);
    chk("box_max_y0", 32'(box_y0), 32'd0);
    set_box(600, 40, 39, 40);
    step(1, "box_edge");
    chk("box_edge_x1", 32'(box_x1), 32'd639);
    chk("box_edge_y0", 32'(box_y0), 32'd0);

    // randomized phase
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 9);
      if (r < 5)      keycode = 8'd0;
      else if (r < 8) keycode = 8'h28;
      else            keycode = 8'($urandom_range(0, 255));
      game_over = ($urandom_range(0, 19) == 0);
      set_box($urandom_range(0, 1023), $urandom_range(0, 1023),
              $urandom_range(0, 1023), $urandom_range(0, 1023));
      if (i % 4 == 0) set_box($urandom_range(0, 700), $urandom_range(0, 520),
                              $urandom_range(0, 80), $urandom_range(0, 60));
      step(1, "rand");
      if ($urandom_range(0, 499) == 0) begin
        #2 Reset = 1'b1;
        #1;
        model_reset();
        check_all("rand_reset");
        #1 Reset = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
